// File: rtl/leb128_u32_stream_pkg.sv
`default_nettype none
// leb128_u32_stream_pkg: shared LEB128 u32 constants, word record and overflow helper.
// Revision 1.0
package leb128_u32_stream_pkg;

  localparam int LEB128_U32_MAX_LEN = 5;
  localparam int LEB128_CONT_BIT    = 7;
  localparam int LEB128_PAYLOAD_W   = 7;
  localparam int LEB128_LEN_W       = 3;

  typedef struct packed {
    logic [31:0]             data;
    logic [LEB128_LEN_W-1:0] len;
    logic                    err;
  } leb128_word_t;

  // Fifth byte may carry only 4 payload bits and must terminate the word.
  function automatic logic leb128_u32_overflow(input logic [7:0] last);
    return last[LEB128_CONT_BIT] | (|last[6:4]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/leb128_u32_stream_unpack.sv
`default_nettype none
// unpack_u32: combinational unsigned LEB128 decode of a 5-byte window into value and length.
// Revision 1.0
module unpack_u32
  import leb128_u32_stream_pkg::*;
(
  input  logic [LEB128_U32_MAX_LEN-1:0][7:0] win,
  output logic [31:0]                        value,
  output logic [LEB128_LEN_W-1:0]            len
);

  always_comb begin
    len = LEB128_LEN_W'(LEB128_U32_MAX_LEN);
    // Descending scan so the lowest terminator wins; no terminator in 4 bytes means 5.
    for (int k = LEB128_U32_MAX_LEN - 2; k >= 0; k--) begin
      if (!win[k][LEB128_CONT_BIT]) len = LEB128_LEN_W'(k + 1);
    end
    value = '0;
    for (int k = 0; k < LEB128_U32_MAX_LEN; k++) begin
      if (LEB128_LEN_W'(k) < len)
        value = value | (32'(win[k][LEB128_PAYLOAD_W-1:0]) << (LEB128_PAYLOAD_W * k));
    end
  end

endmodule
`default_nettype wire

// File: rtl/leb128_u32_stream.sv
`default_nettype none
// leb128_u32_stream: valid/ready byte window feeding unpack_u32, one decoded u32 per word.
// Optional overflow flag via LEB128_U32_ERR_CHECK_EN. Revision 1.0
module leb128_u32_stream
  import leb128_u32_stream_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic [2:0]  m_len,
  output logic        m_err,
  output logic        m_valid,
  input  logic        m_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][7:0]                 byte_buf;
  logic [DEPTH-1:0][7:0]                 buf_shifted;
  logic [DEPTH-1:0][7:0]                 buf_next;
  logic [CNT_W-1:0]                      cnt;
  logic [CNT_W-1:0]                      cnt_next;
  logic [CNT_W-1:0]                      shift;
  logic [CNT_W-1:0]                      wr_idx;
  logic [LEB128_U32_MAX_LEN-1:0][7:0]    win;
  logic [31:0]                           dec_val;
  logic [LEB128_LEN_W-1:0]               dec_len;
  logic                                  complete;
  logic                                  push;
  logic                                  pop;
  leb128_word_t                          word;

  // Slots beyond cnt read as zero so stale bytes never reach the decoder.
  always_comb begin
    for (int k = 0; k < LEB128_U32_MAX_LEN; k++) begin
      win[k] = (CNT_W'(k) < cnt) ? byte_buf[k] : 8'h00;
    end
  end

  unpack_u32 u_unpack (
    .win   (win),
    .value (dec_val),
    .len   (dec_len)
  );

  // A zero-filled slot can look like a terminator; only real bytes complete a word.
  assign complete = (CNT_W'(dec_len) <= cnt);

  assign word.data = dec_val;
  assign word.len  = dec_len;
`ifdef LEB128_U32_ERR_CHECK_EN
  assign word.err  = complete && (dec_len == LEB128_LEN_W'(LEB128_U32_MAX_LEN)) &&
                     leb128_u32_overflow(win[LEB128_U32_MAX_LEN-1]);
`else
  assign word.err  = 1'b0;
`endif

  assign m_valid = complete;
  assign m_data  = word.data;
  assign m_len   = word.len;
  assign m_err   = word.err;

  assign s_ready = !rst && (cnt < CNT_W'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  assign shift    = pop ? CNT_W'(dec_len) : '0;
  assign wr_idx   = cnt - shift;
  assign cnt_next = cnt - shift + CNT_W'(push);

  assign buf_shifted = byte_buf >> {shift, 3'b000};

  always_comb begin
    buf_next = buf_shifted;
    for (int j = 0; j < DEPTH; j++) begin
      if (push && (wr_idx == CNT_W'(j))) buf_next[j] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_buf <= '0;
      cnt      <= '0;
    end else begin
      byte_buf <= buf_next;
      cnt      <= cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leb128_u32_stream.sv
`default_nettype none
// tb_leb128_u32_stream: vector table, directed corner sequences and random traffic vs a queue model.
// Revision 1.0
module tb_leb128_u32_stream;

  localparam int DEPTH = 8;
`ifdef LEB128_U32_ERR_CHECK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic [2:0]  m_len;
  logic        m_err;
  logic        m_valid;
  logic        m_ready;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  pend[$];
  logic [31:0] got[$];

  typedef struct {
    int          n;
    logic [39:0] bytes;
    logic [31:0] d;
    logic [2:0]  l;
    logic        e_chk;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  leb128_u32_stream #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_len   (m_len),
    .m_err   (m_err),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decode the head of the pending byte stream straight from the LEB128 rules.
  function automatic void model_word(output bit ok, output logic [31:0] v,
                                     output logic [2:0] l, output logic e);
    int n = pend.size();
    int len = 0;
    longint unsigned acc = 0;
    for (int k = 0; k < 4 && k < n; k++)
      if (len == 0 && pend[k] < 8'h80) len = k + 1;
    if (len == 0 && n >= 5) len = 5;
    ok = (len != 0);
    for (int k = 0; k < len; k++)
      acc = acc + (longint'(pend[k] & 8'h7f) << (7 * k));
    v = acc[31:0];
    l = 3'(len);
    e = 1'b0;
    if (ERRCHK && len == 5) e = pend[4][7] || (pend[4][6:4] != 3'b000);
  endfunction

  // One clock: drive at the falling edge, check 1ns later, advance the model, wait for next fall.
  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    bit ok;
    logic [31:0] ev;
    logic [2:0]  el;
    logic        ee;
    s_valid = v;
    s_data  = d;
    m_ready = r;
    #1;
    model_word(ok, ev, el, ee);
    chk("s_ready", 32'(s_ready), 32'(pend.size() < DEPTH));
    chk("m_valid", 32'(m_valid), 32'(ok));
    if (ok && m_valid) begin
      chk("m_data", m_data, ev);
      chk("m_len", 32'(m_len), 32'(el));
      chk("m_err", 32'(m_err), 32'(ee));
    end
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      if (ok) for (int k = 0; k < int'(el); k++) void'(pend.pop_front());
    end
    if (s_valid && s_ready) pend.push_back(d);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'haa;
    m_ready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    rst     = 1'b0;
    s_valid = 1'b0;
    pend.delete();
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_len", 32'(m_len), 32'd1);
    chk("rst_m_err", 32'(m_err), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{n:1, bytes:40'h00,         d:32'd0,          l:3'd1, e_chk:1'b0};
    vecs[1] = '{n:3, bytes:40'h268ee5,     d:32'd624485,     l:3'd3, e_chk:1'b0};
    vecs[2] = '{n:1, bytes:40'h7f,         d:32'd127,        l:3'd1, e_chk:1'b0};
    vecs[3] = '{n:2, bytes:40'h0180,       d:32'd128,        l:3'd2, e_chk:1'b0};
    vecs[4] = '{n:4, bytes:40'h7fffffff,   d:32'h0fffffff,   l:3'd4, e_chk:1'b0};
    vecs[5] = '{n:5, bytes:40'h0fffffffff, d:32'hffffffff,   l:3'd5, e_chk:1'b0};
    vecs[6] = '{n:5, bytes:40'h7fffffffff, d:32'hffffffff,   l:3'd5, e_chk:1'b1};
    vecs[7] = '{n:5, bytes:40'h8fffffffff, d:32'hffffffff,   l:3'd5, e_chk:1'b1};
    vecs[8] = '{n:5, bytes:40'h0080808080, d:32'd0,          l:3'd5, e_chk:1'b0};
    vecs[9] = '{n:5, bytes:40'h8181818181, d:32'h10204081,   l:3'd5, e_chk:1'b1};

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Table: push each word with backpressure, then compare the presented word and pop it.
    for (int i = 0; i < NV; i++) begin
      for (int b = 0; b < vecs[i].n; b++) tick(1'b1, vecs[i].bytes[8*b +: 8], 1'b0);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), m_data, vecs[i].d);
      chk($sformatf("vec%0d_len", i), 32'(m_len), 32'(vecs[i].l));
      chk($sformatf("vec%0d_err", i), 32'(m_err), 32'(vecs[i].e_chk & ERRCHK));
      tick(1'b0, 8'h00, 1'b1);
    end

    // e5,8e,26 with m_ready high: word appears the cycle after the last byte.
    tick(1'b1, 8'he5, 1'b1);
    tick(1'b1, 8'h8e, 1'b1);
    tick(1'b1, 8'h26, 1'b1);
    #1;
    chk("seq_valid", 32'(m_valid), 32'd1);
    chk("seq_data", m_data, 32'd624485);
    chk("seq_len", 32'(m_len), 32'd3);
    tick(1'b0, 8'h00, 1'b1);

    // Back-to-back words with simultaneous push and pop.
    begin
      logic [7:0] stream [8] = '{8'h7f, 8'h80, 8'h01, 8'hff, 8'hff, 8'hff, 8'hff, 8'h0f};
      got.delete();
      foreach (stream[i]) tick(1'b1, stream[i], 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
      chk("b2b_count", 32'(got.size()), 32'd3);
      if (got.size() == 3) begin
        chk("b2b_w0", got[0], 32'd127);
        chk("b2b_w1", got[1], 32'd128);
        chk("b2b_w2", got[2], 32'hffffffff);
      end
      chk("b2b_left", 32'(pend.size()), 32'd0);
    end

    // Full buffer under backpressure.
    for (int i = 0; i < 8; i++) tick(1'b1, 8'h81, 1'b0);
    #1;
    chk("full_s_ready", 32'(s_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_data", m_data, 32'h10204081);
      chk("hold_len", 32'(m_len), 32'd5);
      tick(1'b1, 8'h33, 1'b0);
    end
    tick(1'b0, 8'h00, 1'b1);
    #1;
    chk("after_pop_s_ready", 32'(s_ready), 32'd1);
    chk("after_pop_m_valid", 32'(m_valid), 32'd0);
    tick(1'b1, 8'h81, 1'b0);
    tick(1'b1, 8'h81, 1'b0);
    tick(1'b0, 8'h00, 1'b1);

    // Reset mid-word drops the partial bytes.
    tick(1'b1, 8'he5, 1'b0);
    tick(1'b1, 8'h8e, 1'b0);
    do_reset(1);
    tick(1'b1, 8'h26, 1'b0);
    #1;
    chk("post_rst_valid", 32'(m_valid), 32'd1);
    chk("post_rst_data", m_data, 32'd38);
    chk("post_rst_len", 32'(m_len), 32'd1);
    tick(1'b0, 8'h00, 1'b1);

    // Random traffic with varying downstream pressure.
    for (int seg = 0; seg < 8; seg++) begin
      int rdy_pct = (seg % 4) * 30 + 5;
      for (int i = 0; i < 500; i++) begin
        logic [7:0] rb = 8'($urandom);
        tick(($urandom % 4) != 0, rb, int'($urandom_range(0, 99)) < rdy_pct);
      end
    end
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00, 1'b1);
    do_reset(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
